// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package mc_controller_pkg;

    localparam int unsigned ST_W    = 4;
    localparam int unsigned INSTR_W = 20;

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    // Instruction bits [31:12] as seen by the controller.
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rn;
        logic [3:0] rd;
    } instr_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b0101;
    localparam logic [3:0] ALU_EOR = 4'b0110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ARM condition evaluation against {N,Z,C,V}; 1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_controller_mainfsm.sv
// Main sequencer: state register, next-state logic and raw (ungated) enables.
module mc_controller_mainfsm
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_op,
    input  logic       i_funct5,
    input  logic       i_funct0,
    input  logic       i_mem_ready,
    output state_t     o_state,
    output logic       o_adr_src_c,
    output logic       o_alu_src_a_c,
    output logic [1:0] o_alu_src_b_c,
    output logic [1:0] o_result_src_c,
    output logic       o_fetch_c,
    output logic       o_reg_w_c,
    output logic       o_mem_w_c,
    output logic       o_branch_c,
    output logic       o_alu_op_c,
    output logic       o_fault_c
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        o_adr_src_c    = 1'b0;
        o_alu_src_a_c  = 1'b0;
        o_alu_src_b_c  = SRCB_RD2;
        o_result_src_c = RES_ALUOUT;
        o_fetch_c      = 1'b0;
        o_reg_w_c      = 1'b0;
        o_mem_w_c      = 1'b0;
        o_branch_c     = 1'b0;
        o_alu_op_c     = 1'b0;
        o_fault_c      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_alu_src_a_c  = 1'b1;
                o_alu_src_b_c  = SRCB_FOUR;
                o_result_src_c = RES_ALURES;
                o_fetch_c      = 1'b1;
                if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                o_alu_src_a_c = 1'b1;
                o_alu_src_b_c = SRCB_FOUR;
                case (i_op)
                    OP_MEM:  w_next = S_MEMADR;
                    OP_DP:   w_next = i_funct5 ? S_EXECI : S_EXECR;
                    OP_BR:   w_next = S_BRANCH;
                    default: w_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                o_alu_src_b_c = SRCB_IMM;
                w_next        = i_funct0 ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_adr_src_c = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_result_src_c = RES_DATA;
                o_reg_w_c      = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEMWR: begin
                o_adr_src_c = 1'b1;
                o_mem_w_c   = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                o_alu_op_c = 1'b1;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                o_alu_src_b_c = SRCB_IMM;
                o_alu_op_c    = 1'b1;
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_w_c = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_b_c  = SRCB_IMM;
                o_result_src_c = RES_ALURES;
                o_branch_c     = 1'b1;
                w_next         = S_FETCH;
            end
            S_UNKNOWN: begin
                o_fault_c = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: ALU decode, NZCV flag register, condition check and enable gating.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [3:0]         ALUControl,
    output logic               MemByte,
    output logic               Fault,
    output logic [STATE_W-1:0] State
);

    instr_t     w_ir;
    state_t     w_state;
    logic       w_fetch, w_reg_w, w_mem_w, w_branch, w_alu_op, w_fault;
    logic       w_cond_ex, w_flag_we, w_arith, w_pc_from_rd;
    logic [3:0] w_cmd, w_alu_dp;
    logic [3:0] r_flags;
    logic       w_unused;

    assign w_ir     = instr_t'(Instr);
    assign w_cmd    = w_ir.funct[4:1];
    assign w_unused = &{1'b0, w_ir.rn};

    mc_controller_mainfsm u_mainfsm (
        .clk            (clk),
        .rst_n          (reset),
        .i_op           (w_ir.op),
        .i_funct5       (w_ir.funct[5]),
        .i_funct0       (w_ir.funct[0]),
        .i_mem_ready    (MemReady),
        .o_state        (w_state),
        .o_adr_src_c    (AdrSrc),
        .o_alu_src_a_c  (ALUSrcA),
        .o_alu_src_b_c  (ALUSrcB),
        .o_result_src_c (ResultSrc),
        .o_fetch_c      (w_fetch),
        .o_reg_w_c      (w_reg_w),
        .o_mem_w_c      (w_mem_w),
        .o_branch_c     (w_branch),
        .o_alu_op_c     (w_alu_op),
        .o_fault_c      (w_fault)
    );

    always_comb begin
        w_alu_dp = ALU_ADD;
        case (w_cmd)
            CMD_ADD: w_alu_dp = ALU_ADD;
            CMD_SUB: w_alu_dp = ALU_SUB;
            CMD_AND: w_alu_dp = ALU_AND;
            CMD_ORR: w_alu_dp = ALU_ORR;
            CMD_EOR: w_alu_dp = ALU_EOR;
            default: w_alu_dp = ALU_ADD;
        endcase
    end

    assign ALUControl = w_alu_op ? w_alu_dp : ALU_ADD;
    assign w_arith    = (w_cmd == CMD_ADD) || (w_cmd == CMD_SUB);
    assign w_cond_ex  = cond_check(w_ir.cond, r_flags);
    assign w_flag_we  = w_alu_op & w_ir.funct[0] & w_cond_ex;

    // NZ follow every flag-setting op; CV only change on arithmetic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_flag_we)           r_flags[3:2] <= ALUFlags[3:2];
            if (w_flag_we & w_arith) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // A writeback to r15 is steered into the PC instead of the register file.
    assign w_pc_from_rd = w_reg_w & w_cond_ex & (w_ir.rd == 4'd15);

    assign PCWrite  = reset & ((w_fetch & MemReady) | (w_branch & w_cond_ex) | w_pc_from_rd);
    assign IRWrite  = reset & w_fetch & MemReady;
    assign RegWrite = reset & w_reg_w & w_cond_ex & ~w_pc_from_rd;
    assign MemWrite = reset & w_mem_w & w_cond_ex;
    assign Fault    = reset & w_fault;

    assign ImmSrc  = w_ir.op;
    assign RegSrc  = {w_ir.op == OP_MEM, w_ir.op == OP_BR};
    assign MemByte = (w_ir.op == OP_MEM) & w_ir.funct[2];
    assign State   = STATE_W'(w_state);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expectations queued with stimulus, checked before each edge.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, MemByte, Fault;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  State;

    always #5 clk = ~clk;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .MemByte    (MemByte),
        .Fault      (Fault),
        .State      (State)
    );

    // en = {PCWrite, IRWrite, RegWrite, MemWrite, Fault}
    typedef struct packed {
        logic [3:0] st;
        logic [4:0] en;
        logic [3:0] alu;
        logic [1:0] imm;
        logic       mb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Datapath selects the state table pins down: {mask, value} over {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}.
    function automatic logic [11:0] sel_model(input logic [3:0] st);
        case (st)
            4'd0:    return {6'b111111, 6'b0_1_10_10};
            4'd1:    return {6'b011100, 6'b0_1_10_00};
            4'd2:    return {6'b011100, 6'b0_0_01_00};
            4'd3:    return {6'b100000, 6'b1_0_00_00};
            4'd4:    return {6'b000011, 6'b0_0_00_01};
            4'd5:    return {6'b100000, 6'b1_0_00_00};
            4'd6:    return {6'b011100, 6'b0_0_00_00};
            4'd7:    return {6'b011100, 6'b0_0_01_00};
            4'd8:    return {6'b000011, 6'b0_0_00_00};
            4'd9:    return {6'b011111, 6'b0_0_01_10};
            default: return 12'd0;
        endcase
    endfunction

    task automatic expect_now(input logic [3:0] st, input logic [4:0] en, input logic [3:0] alu);
        exp_t e;
        logic [19:0] ins;
        ins   = Instr;
        e.st  = st;
        e.en  = en;
        e.alu = alu;
        e.imm = ins[15:14];
        e.mb  = (ins[15:14] == 2'b01) && ins[10];
        sb_q.push_back(e);
    endtask

    task automatic check_cycle(input string nm);
        exp_t        e;
        logic [11:0] sm;
        logic [5:0]  obs_sel;
        if (sb_q.size() == 0) begin
            check_val({nm, ".sb_empty"}, 32'(1), 32'(0));
            return;
        end
        e  = sb_q.pop_front();
        sm = sel_model(e.st);
        obs_sel = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
        check_val($sformatf("%s.state", nm), 32'(State), 32'(e.st));
        check_val($sformatf("%s.en@%0d", nm, e.st),
                  32'({PCWrite, IRWrite, RegWrite, MemWrite, Fault}), 32'(e.en));
        check_val($sformatf("%s.alu@%0d", nm, e.st), 32'(ALUControl), 32'(e.alu));
        check_val($sformatf("%s.imm", nm), 32'(ImmSrc), 32'(e.imm));
        check_val($sformatf("%s.membyte", nm), 32'(MemByte), 32'(e.mb));
        if (sm[11:6] != 6'd0)
            check_val($sformatf("%s.sel@%0d", nm, e.st), 32'(obs_sel & sm[11:6]), 32'(sm[5:0]));
    endtask

    // Drive one cycle, queue its expectation, check mid-cycle, advance past the next edge.
    task automatic step(input string nm, input logic [19:0] ins, input logic mr, input logic [3:0] fl,
                        input logic [3:0] st, input logic [4:0] en, input logic [3:0] alu);
        Instr    = ins;
        MemReady = mr;
        ALUFlags = fl;
        expect_now(st, en, alu);
        #2;
        check_cycle(nm);
        @(posedge clk);
        #1;
    endtask

    // Plain fetch + decode prologue shared by every instruction.
    task automatic fetch_decode(input string nm, input logic [19:0] ins, input logic [3:0] fl);
        step(nm, ins, 1'b1, fl, 4'd0, 5'b11000, 4'b0000);
        step(nm, ins, 1'b0, fl, 4'd1, 5'b00000, 4'b0000);
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 20'hE2821, 1'b1, 4'h0, 4'd0, 5'b00000, 4'b0000);
        reset = 1'b1;

        // ADD r1,r2,#imm (AL)
        fetch_decode("addi", 20'hE2821, 4'h0);
        step("addi", 20'hE2821, 1'b0, 4'h0, 4'd7, 5'b00000, 4'b0000);
        step("addi", 20'hE2821, 1'b0, 4'h0, 4'd8, 5'b00100, 4'b0000);

        // LDR with a two-cycle memory stall
        fetch_decode("ldr", 20'hE5921, 4'h0);
        step("ldr", 20'hE5921, 1'b1, 4'h0, 4'd2, 5'b00000, 4'b0000);
        step("ldr", 20'hE5921, 1'b0, 4'h0, 4'd3, 5'b00000, 4'b0000);
        step("ldr", 20'hE5921, 1'b0, 4'h0, 4'd3, 5'b00000, 4'b0000);
        step("ldr", 20'hE5921, 1'b1, 4'h0, 4'd3, 5'b00000, 4'b0000);
        step("ldr", 20'hE5921, 1'b0, 4'h0, 4'd4, 5'b00100, 4'b0000);

        // SUBS r1,r1,r1 -> Z=1, C=1
        fetch_decode("subs", 20'hE0511, 4'b0110);
        step("subs", 20'hE0511, 1'b0, 4'b0110, 4'd6, 5'b00000, 4'b0010);
        step("subs", 20'hE0511, 1'b0, 4'b0000, 4'd8, 5'b00100, 4'b0000);

        // STRNE is suppressed while Z=1
        fetch_decode("strne", 20'h15821, 4'h0);
        step("strne", 20'h15821, 1'b0, 4'h0, 4'd2, 5'b00000, 4'b0000);
        step("strne", 20'h15821, 1'b0, 4'h0, 4'd5, 5'b00000, 4'b0000);
        step("strne", 20'h15821, 1'b1, 4'h0, 4'd5, 5'b00000, 4'b0000);

        // BEQ taken with Z=1
        fetch_decode("beq_t", 20'h0A000, 4'h0);
        step("beq_t", 20'h0A000, 1'b0, 4'h0, 4'd9, 5'b10000, 4'b0000);

        // ADDS #imm -> NZCV=0010
        fetch_decode("adds", 20'hE2921, 4'b0010);
        step("adds", 20'hE2921, 1'b0, 4'b0010, 4'd7, 5'b00000, 4'b0000);
        step("adds", 20'hE2921, 1'b0, 4'b1111, 4'd8, 5'b00100, 4'b0000);

        // BEQ not taken with Z=0
        fetch_decode("beq_n", 20'h0A000, 4'h0);
        step("beq_n", 20'h0A000, 1'b0, 4'h0, 4'd9, 5'b00000, 4'b0000);

        // ANDS with ALU NZCV=0101: Z loads, C/V keep 1/0
        fetch_decode("ands", 20'hE0111, 4'b0101);
        step("ands", 20'hE0111, 1'b0, 4'b0101, 4'd6, 5'b00000, 4'b0100);
        step("ands", 20'hE0111, 1'b0, 4'b0000, 4'd8, 5'b00100, 4'b0000);

        fetch_decode("bcs", 20'h2A000, 4'h0);
        step("bcs", 20'h2A000, 1'b0, 4'h0, 4'd9, 5'b10000, 4'b0000);
        fetch_decode("bvs", 20'h6A000, 4'h0);
        step("bvs", 20'h6A000, 1'b0, 4'h0, 4'd9, 5'b00000, 4'b0000);

        // STRB (AL): MemWrite held until MemReady
        fetch_decode("strb", 20'hE5C21, 4'h0);
        step("strb", 20'hE5C21, 1'b0, 4'h0, 4'd2, 5'b00000, 4'b0000);
        step("strb", 20'hE5C21, 1'b0, 4'h0, 4'd5, 5'b00010, 4'b0000);
        step("strb", 20'hE5C21, 1'b1, 4'h0, 4'd5, 5'b00010, 4'b0000);

        // ADD pc,r2,#imm: writeback goes to the PC
        fetch_decode("addpc", 20'hE282F, 4'h0);
        step("addpc", 20'hE282F, 1'b0, 4'h0, 4'd7, 5'b00000, 4'b0000);
        step("addpc", 20'hE282F, 1'b0, 4'h0, 4'd8, 5'b10000, 4'b0000);

        fetch_decode("eor", 20'hE0211, 4'h0);
        step("eor", 20'hE0211, 1'b0, 4'h0, 4'd6, 5'b00000, 4'b0110);
        step("eor", 20'hE0211, 1'b0, 4'h0, 4'd8, 5'b00100, 4'b0000);
        fetch_decode("orr", 20'hE1811, 4'h0);
        step("orr", 20'hE1811, 1'b0, 4'h0, 4'd6, 5'b00000, 4'b0101);
        step("orr", 20'hE1811, 1'b0, 4'h0, 4'd8, 5'b00100, 4'b0000);

        // Op=11 faults for one cycle
        fetch_decode("undef", 20'hEC000, 4'h0);
        step("undef", 20'hEC000, 1'b1, 4'h0, 4'd10, 5'b00001, 4'b0000);

        // Async reset in the middle of a stalled store
        fetch_decode("str_rst", 20'hE5821, 4'h0);
        step("str_rst", 20'hE5821, 1'b0, 4'h0, 4'd2, 5'b00000, 4'b0000);
        MemReady = 1'b0;
        expect_now(4'd5, 5'b00010, 4'b0000);
        #2;
        check_cycle("str_rst");
        #2;
        reset = 1'b0;
        expect_now(4'd0, 5'b00000, 4'b0000);
        #1;
        check_cycle("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Flags were cleared: BEQ must not branch although Z was 1 before reset
        fetch_decode("beq_rst", 20'h0A000, 4'h0);
        step("beq_rst", 20'h0A000, 1'b0, 4'h0, 4'd9, 5'b00000, 4'b0000);
        step("final", 20'hE2821, 1'b0, 4'h0, 4'd0, 5'b00000, 4'b0000);

        check_val("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
